// File: rtl/lsu_pkg.sv
// Shared load/store types: data-type encodings (also used by the ALU decoder),
// FSM states and the default bus-timeout depth.
package lsu_pkg;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_BYTE = 2'b01,
    DT_HALF = 2'b10
  } data_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  localparam int TIMEOUT_DEF = 16;

  // Reserved type (2'b11) is always rejected; bytes can sit on any lane.
  function automatic logic is_misaligned(input logic [1:0] dtype, input logic [1:0] addr_lo);
    case (dtype)
      DT_WORD: return (addr_lo != 2'b00);
      DT_HALF: return addr_lo[0];
      DT_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data aligner: shifts the addressed lane down to bit 0
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  dtype,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sx;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign sx      = ~is_unsigned;

  always_comb begin
    data = shifted;
    case (dtype)
      DT_BYTE: data = {{24{sx & shifted[7]}}, shifted[7:0]};
      DT_HALF: data = {{16{sx & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_data_unit.sv
// Load/store data unit: single-outstanding request, alignment check, lane-shifted
// bus access with byte enables, extended load return and an ack timeout.
module lsu_data_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_type,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  lsu_state_e  state;
  logic [7:0]  cnt;
  logic [1:0]  addr_lo_q;
  logic [1:0]  dtype_q;
  logic        uns_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_data;
  logic        bad_req;

  assign bad_req = is_misaligned(req_type, req_addr[1:0]);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_type)
      DT_BYTE: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      DT_HALF: begin
        be_next    = 4'b0011 << req_addr[1:0];
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  lsu_load_align u_align (
    .rdata       (mem_rdata),
    .addr_lo     (addr_lo_q),
    .dtype       (dtype_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      cnt        <= '0;
      addr_lo_q  <= '0;
      dtype_q    <= '0;
      uns_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            dtype_q   <= req_type;
            uns_q     <= req_unsigned;
            req_ready <= 1'b0;
            cnt       <= '0;
            if (bad_req) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= ST_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {req_addr[AW-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        ST_BUSY: begin
          // An ack on the final timeout cycle still wins.
          if (mem_ack) begin
            state      <= ST_RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= mem_we ? 32'd0 : load_data;
            cnt        <= '0;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state      <= ST_RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          cnt        <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_data_unit.md
Name: lsu_data_unit

Overview:
- Load/store data unit between the execute stage and the data-memory bus; the consumer of the ALU decoder's DataType and funct3 signals.
- Accepts one load/store request at a time and checks alignment. Issues a word-aligned bus access with byte enables and lane-shifted write data.
- Returns load data shifted down to bit 0 and sign- or zero-extended. A timeout counter guards against a missing bus acknowledge.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before abort; legal range 1..255.
- AW, 32: address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  execute-stage request strobe
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_type  in  2  DataType: 00 word, 01 byte, 10 half, 11 reserved
- req_unsigned  in  1  funct3[2]; 1 = zero-extend load (LBU/LHU)
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, LSBs significant
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, reserved type, or timeout; valid with resp_valid
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write
- mem_addr  out  AW  req_addr with bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  bus completion; read data valid same cycle
- mem_rdata  in  32  bus read data

Behaviour:
- Reset values:
  - State IDLE, req_ready=1.
  - All other outputs 0, timeout counter 0.
  - Reset asserted mid-access drops mem_req immediately; no response is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE, req_valid=1 (acceptance cycle):
  - Register all request fields.
  - Misaligned or reserved request → RESP with err=1; mem_req is never raised.
  - Otherwise → BUSY.
- Misalignment:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
  - req_type=11 is always an error.
- BUSY:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are stable from the cycle after acceptance until mem_ack.
  - mem_ack=1 → latch the extracted load data, then go to RESP with err=0.
  - Counter increments each BUSY cycle without ack. At counter==TIMEOUT-1 with no ack → RESP with err=1, mem_req dropped.
  - mem_ack in the same cycle as the timeout condition counts as success.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. Counter clears.
- Latency: acceptance at cycle 0; mem_req from cycle 1; ack at cycle k≥1 → resp_valid at cycle k+1. Minimum 2 cycles. Error path: resp_valid at cycle 1.
- mem_ack outside BUSY is ignored.
- req_valid outside IDLE is ignored (req_ready=0); the requester holds the request.
- Byte enables and store lanes:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: be = 1111, wdata unchanged.
- Load extraction:
  - Shift mem_rdata right by 8·addr[1:0].
  - Take 8 or 16 or 32 bits; sign-extend unless req_unsigned=1.
  - req_unsigned is ignored for word loads.
- resp_rdata holds its value until the next RESP; it is 0 for stores and errors.

Decomposition:
- Shared package lsu_pkg:
  - DataType enum (DT_WORD=2'b00, DT_BYTE=2'b01, DT_HALF=2'b10).
  - FSM state enum.
  - TIMEOUT default constant.
- The ALU decoder imports the same DataType enum so the encodings cannot diverge.
- One sub-module: lsu_load_align, purely combinational. Inputs: mem_rdata, addr[1:0], type, unsigned. Output: extended 32-bit data.
- Lane and byte-enable generation stays inline.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, ack at cycle 3 → mem_addr=0x1000, be=1000, mem_wdata=0xABABABAB; resp_valid at cycle 4, err=0, rdata=0.
- Signed load half: addr=0x2002, mem_rdata=0x8001_1234, ack in first BUSY cycle → rdata=0xFFFF8001.
- Unsigned load half at the same address and data → rdata=0x00008001.
- Load word: addr=0x2001 → resp_valid at cycle 1, err=1, mem_req never high.
- Load byte: addr=0x10, no mem_ack with TIMEOUT=4 → mem_req high for 4 cycles, then resp_err=1. Repeat with ack on the 4th cycle → err=0.
- Reset asserted in BUSY → mem_req=0 immediately, no resp_valid, req_ready=1 after release. A back-to-back request accepted the cycle after RESP is serviced normally.
